// File: rtl/hazard_ctrl.sv
// Decode-stage pipeline sequencer: load-use bubbles, wrong-path flushes and memory-busy freeze.
// Optional perf counters (stall_cnt, flush_cnt) are built only when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic             uses_rt,
    input  logic             jump_2,
    input  logic             memRead_3,
    input  logic [4:0]       rt_3,
    input  logic             branch_taken_3,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned BUB_W = 3;
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_STALL  = 2'd1;
    localparam logic [1:0] ST_FREEZE = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [1:0]       saved, saved_nxt;
    logic [BUB_W-1:0] bub_cnt, bub_nxt;
    logic [1:0]       eff_state;
    logic             hit;

    // FREEZE is transparent once mem_busy drops: the held state acts in that same cycle
    assign eff_state = (state == ST_FREEZE) ? saved : state;

    assign hit = memRead_3 && (rt_3 != 5'd0) &&
                 ((rt_3 == rs) || (uses_rt && (rt_3 == rt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            saved   <= ST_RUN;
            bub_cnt <= '0;
        end else begin
            state   <= state_nxt;
            saved   <= saved_nxt;
            bub_cnt <= bub_nxt;
        end
    end

    // Next state and pipeline controls, in priority order
    always_comb begin
        state_nxt  = eff_state;
        saved_nxt  = saved;
        bub_nxt    = bub_cnt;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_write = 1'b1;
        idex_flush = 1'b0;

        if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            state_nxt  = ST_FREEZE;
            saved_nxt  = eff_state;
        end else if (branch_taken_3) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_nxt  = ST_RUN;
            bub_nxt    = '0;
        end else if (eff_state == ST_STALL) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            bub_nxt    = bub_cnt - BUB_W'(1);
            if (bub_cnt <= BUB_W'(1)) begin
                state_nxt = ST_RUN;
            end
        end else if (hit) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            if (STALL_CYCLES > 1) begin
                state_nxt = ST_STALL;
                bub_nxt   = BUB_W'(STALL_CYCLES - 1);
            end
        end else if (jump_2) begin
            ifid_flush = 1'b1;
        end

        // Reset holds the pipe closed and flushes both stage registers
        if (!rst_n) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic bubble_ev;
    logic flush_ev;

    // A bubble is idex_flush without ifid_flush; a flush event redirects the PC
    assign bubble_ev = idex_flush && !ifid_flush;
    assign flush_ev  = ifid_flush && pc_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (bubble_ev && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_ev && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (1 and 3 bubbles) share stimulus;
// each directed vector names which instance it checks.
module tb_hazard_ctrl;

    localparam logic [4:0] IDLE = 5'b11010; // {pc_w, ifid_w, ifid_f, idex_w, idex_f}
    localparam logic [4:0] BUB  = 5'b00011;
    localparam logic [4:0] BR   = 5'b11111;
    localparam logic [4:0] JMP  = 5'b11110;
    localparam logic [4:0] FRZ  = 5'b00000;
    localparam logic [4:0] RST  = 5'b00101;

    typedef struct {
        logic        sel;
        logic [4:0]  outs;
        logic [15:0] sc;
        logic [15:0] fc;
        string       name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs, rt, rt_3;
    logic       uses_rt, jump_2, memRead_3, branch_taken_3, mem_busy;

    logic        pc_a, ifw_a, iff_a, idw_a, idf_a;
    logic        pc_b, ifw_b, iff_b, idw_b, idf_b;
    logic [1:0]  sc_a, fc_a;
    logic [15:0] sc_b, fc_b;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(2)) u_a (
        .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .uses_rt(uses_rt), .jump_2(jump_2),
        .memRead_3(memRead_3), .rt_3(rt_3), .branch_taken_3(branch_taken_3),
        .mem_busy(mem_busy), .pc_write(pc_a), .ifid_write(ifw_a), .ifid_flush(iff_a),
        .idex_write(idw_a), .idex_flush(idf_a), .stall_cnt(sc_a), .flush_cnt(fc_a)
    );

    hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .uses_rt(uses_rt), .jump_2(jump_2),
        .memRead_3(memRead_3), .rt_3(rt_3), .branch_taken_3(branch_taken_3),
        .mem_busy(mem_busy), .pc_write(pc_b), .ifid_write(ifw_b), .ifid_flush(iff_b),
        .idex_write(idw_b), .idex_flush(idf_b), .stall_cnt(sc_b), .flush_cnt(fc_b)
    );

    // Counters read zero when the perf feature is not built
    function automatic logic [15:0] cnt(input int v);
`ifdef HAZ_PERF_CNT_EN
        return 16'(v);
`else
        return 16'(v * 0);
`endif
    endfunction

    task automatic step(input string nm, input logic r,
                        input logic [4:0] rs_v, input logic [4:0] rt_v, input logic ur,
                        input logic j, input logic mr, input logic [4:0] rt3,
                        input logic br, input logic busy, input logic sel,
                        input logic [4:0] eo, input int es, input int ef);
        exp_t e;
        rst_n          = r;
        rs             = rs_v;
        rt             = rt_v;
        uses_rt        = ur;
        jump_2         = j;
        memRead_3      = mr;
        rt_3           = rt3;
        branch_taken_3 = br;
        mem_busy       = busy;
        e.sel  = sel;
        e.outs = eo;
        e.sc   = cnt(es);
        e.fc   = cnt(ef);
        e.name = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [4:0]  got;
            logic [15:0] gsc, gfc;
            e   = q.pop_front();
            got = e.sel ? {pc_b, ifw_b, iff_b, idw_b, idf_b} : {pc_a, ifw_a, iff_a, idw_a, idf_a};
            gsc = e.sel ? sc_b : 16'(sc_a);
            gfc = e.sel ? fc_b : 16'(fc_a);
            checks = checks + 3;
            if (got !== e.outs) begin
                errors = errors + 1;
                $display("FAIL %s ctrl got %b want %b", e.name, got, e.outs);
            end
            if (gsc !== e.sc) begin
                errors = errors + 1;
                $display("FAIL %s stall_cnt got %0d want %0d", e.name, gsc, e.sc);
            end
            if (gfc !== e.fc) begin
                errors = errors + 1;
                $display("FAIL %s flush_cnt got %0d want %0d", e.name, gfc, e.fc);
            end
        end
    end

    initial begin
        rst_n = 1'b0; rs = '0; rt = '0; rt_3 = '0;
        uses_rt = 1'b0; jump_2 = 1'b0; memRead_3 = 1'b0; branch_taken_3 = 1'b0; mem_busy = 1'b0;
        @(posedge clk);
        #1;
        //    name        r  rs rt ur j mr rt3 br bz sel exp  sc  fc
        step("rst_a",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0, 0);
        step("rst_b",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RST, 0, 0);
        // single-bubble instance: load-use on rs, then release
        step("t1_haz",    1, 2, 0, 0, 0, 1, 2, 0, 0, 0, BUB, 0, 0);
        step("t1_rel",    1, 2, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 1, 0);
        step("t1_idle",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 1, 0);
        step("t3_rt0",    1, 0, 0, 0, 0, 1, 0, 0, 0, 0, IDLE, 1, 0);
        step("t3_nort",   1, 1, 5, 0, 0, 1, 5, 0, 0, 0, IDLE, 1, 0);
        step("t3_rt",     1, 1, 5, 1, 0, 1, 5, 0, 0, 0, BUB, 1, 0);
        step("t3_rel",    1, 1, 5, 1, 0, 0, 5, 0, 0, 0, IDLE, 2, 0);
        // 2-bit counter saturates at 3
        step("sat_haz",   1, 3, 0, 0, 0, 1, 3, 0, 0, 0, BUB, 2, 0);
        step("sat_rel",   1, 3, 0, 0, 0, 0, 3, 0, 0, 0, IDLE, 3, 0);
        step("sat_haz2",  1, 3, 0, 0, 0, 1, 3, 0, 0, 0, BUB, 3, 0);
        step("sat_hold",  1, 3, 0, 0, 0, 0, 3, 0, 0, 0, IDLE, 3, 0);
        step("a_jmp",     1, 0, 0, 0, 1, 0, 0, 0, 0, 0, JMP, 3, 0);
        step("a_idle",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 3, 1);
        // three-bubble instance from a clean reset
        step("rst_b2",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RST, 0, 0);
        step("t2_haz",    1, 2, 0, 0, 0, 1, 2, 0, 0, 1, BUB, 0, 0);
        step("t2_bub2",   1, 2, 0, 0, 0, 0, 0, 0, 0, 1, BUB, 1, 0);
        step("t2_bub3",   1, 2, 0, 0, 0, 0, 0, 0, 0, 1, BUB, 2, 0);
        step("t2_run",    1, 2, 0, 0, 0, 0, 0, 0, 0, 1, IDLE, 3, 0);
        step("t4_haz",    1, 2, 0, 0, 0, 1, 2, 0, 0, 1, BUB, 3, 0);
        step("t4_br",     1, 2, 0, 0, 0, 0, 0, 1, 0, 1, BR, 4, 0);
        step("t4_run",    1, 2, 0, 0, 0, 0, 0, 0, 0, 1, IDLE, 4, 1);
        step("t5_haz",    1, 2, 0, 0, 0, 1, 2, 0, 0, 1, BUB, 4, 1);
        step("t5_frz1",   1, 2, 0, 0, 0, 0, 0, 0, 1, 1, FRZ, 5, 1);
        step("t5_frz2",   1, 2, 0, 0, 0, 0, 0, 0, 1, 1, FRZ, 5, 1);
        step("t5_frz3",   1, 2, 0, 0, 0, 0, 0, 0, 1, 1, FRZ, 5, 1);
        step("t5_frz4",   1, 2, 0, 0, 0, 0, 0, 0, 1, 1, FRZ, 5, 1);
        step("t5_bub2",   1, 2, 0, 0, 0, 0, 0, 0, 0, 1, BUB, 5, 1);
        step("t5_bub3",   1, 2, 0, 0, 0, 0, 0, 0, 0, 1, BUB, 6, 1);
        step("t5_run",    1, 2, 0, 0, 0, 0, 0, 0, 0, 1, IDLE, 7, 1);
        step("t6_jhaz",   1, 2, 0, 0, 1, 1, 2, 0, 0, 1, BUB, 7, 1);
        step("t6_jbub2",  1, 2, 0, 0, 1, 0, 0, 0, 0, 1, BUB, 8, 1);
        step("t6_jbub3",  1, 2, 0, 0, 1, 0, 0, 0, 0, 1, BUB, 9, 1);
        step("t6_jrel",   1, 2, 0, 0, 1, 0, 0, 0, 0, 1, JMP, 10, 1);
        step("t6_idle",   1, 0, 0, 0, 0, 0, 0, 0, 0, 1, IDLE, 10, 2);
        step("t6_haz",    1, 2, 0, 0, 0, 1, 2, 0, 0, 1, BUB, 10, 2);
        step("t6_rst",    0, 2, 0, 0, 0, 0, 0, 0, 0, 1, RST, 0, 0);
        step("t6_after",  1, 2, 0, 0, 0, 0, 0, 0, 0, 1, IDLE, 0, 0);
        // busy outranks branch; branch then flushes once released
        step("pri_busy",  1, 0, 0, 0, 0, 0, 0, 1, 1, 1, FRZ, 0, 0);
        step("pri_br",    1, 0, 0, 0, 0, 0, 0, 1, 0, 1, BR, 0, 0);
        step("pri_idle",  1, 0, 0, 0, 0, 0, 0, 0, 0, 1, IDLE, 0, 1);

        for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain pending %0d want 0", q.size());
        end
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
